// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and default configuration values for the
//                pushbutton conditioner (FSM state encoding, timing defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

   // Debounce FSM states: settled low, qualifying high, settled high,
   // qualifying low.
   typedef enum logic [1:0] {
      S_ZERO  = 2'd0,
      S_WAIT1 = 2'd1,
      S_ONE   = 2'd2,
      S_WAIT0 = 2'd3
   } btn_state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 1000000;   // 10 ms at 100 MHz
   localparam int DEF_REPEAT_DELAY  = 50000000;  // 500 ms at 100 MHz
   localparam int DEF_REPEAT_PERIOD = 10000000;  // 100 ms at 100 MHz

   // Larger of two integers, used to size the auto-repeat counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bit_sync
//  Description : Multi-flop synchroniser for a single asynchronous bit.
//                All flops clear to 0 on the asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   // Shift the raw input through the flop chain; the oldest stage is the output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Synchronises and debounces one raw pushbutton, producing a
//                clean level plus one-cycle press / release strobes.
//                Optional auto-repeat of the press strobe while the button is
//                held is enabled by defining BTN_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int TW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [TW-1:0] c_stable_max = TW'(STABLE_CYCLES - 1);

   logic        w_sync_btn;
   btn_state_t  r_state;
   btn_state_t  w_state_nxt;
   logic [TW-1:0] r_timer;
   logic        w_timer_done;
   logic        w_debounce_press;
   logic        w_repeat_fire;
   logic        w_level_nxt;
   logic        w_press_nxt;
   logic        w_release_nxt;
   logic        r_level;
   logic        r_press;
   logic        r_release;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (btn_in),
      .o_q (w_sync_btn)
   );

   assign w_timer_done = (r_timer == c_stable_max);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_ZERO;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: a level change is accepted only after the timer has
   // seen the new value for the full stable window.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_ZERO:  if (w_sync_btn)        w_state_nxt = S_WAIT1;
         S_WAIT1: if (!w_sync_btn)       w_state_nxt = S_ZERO;
                  else if (w_timer_done) w_state_nxt = S_ONE;
         S_ONE:   if (!w_sync_btn)       w_state_nxt = S_WAIT0;
         S_WAIT0: if (w_sync_btn)        w_state_nxt = S_ONE;
                  else if (w_timer_done) w_state_nxt = S_ZERO;
         default:                        w_state_nxt = S_ZERO;
      endcase
   end

   // Debounce timer: cleared on every state change, counts in the qualifying
   // states and saturates at the stable threshold instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timer <= '0;
      end else if (w_state_nxt != r_state) begin
         r_timer <= '0;
      end else if (((r_state == S_WAIT1) || (r_state == S_WAIT0)) && !w_timer_done) begin
         r_timer <= r_timer + 1'b1;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [RW-1:0] c_delay_max  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] c_period_max = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] r_rpt_cnt;
   logic          r_rpt_first;
   logic [RW-1:0] w_rpt_target;

   assign w_rpt_target  = r_rpt_first ? c_delay_max : c_period_max;
   assign w_repeat_fire = (r_state == S_ONE) && (r_rpt_cnt == w_rpt_target);

   // Repeat counter: restarts on each accepted press, runs only while settled
   // high (holding through a qualifying-low glitch) and restarts after firing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rpt_cnt   <= '0;
         r_rpt_first <= 1'b0;
      end else if (w_debounce_press) begin
         r_rpt_cnt   <= '0;
         r_rpt_first <= 1'b1;
      end else if (w_repeat_fire) begin
         r_rpt_cnt   <= '0;
         r_rpt_first <= 1'b0;
      end else if (r_state == S_ONE) begin
         r_rpt_cnt   <= r_rpt_cnt + 1'b1;
      end
   end
`else
   // Repeat timing is irrelevant without auto-repeat; fold it away.
   logic w_unused_rpt_cfg;
   assign w_unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
   assign w_repeat_fire    = 1'b0;
`endif

   // Output decode: level follows the next state so it moves on the same
   // edge as the strobe announcing the change.
   always_comb begin
      w_debounce_press = (r_state == S_WAIT1) && (w_state_nxt == S_ONE);
      w_release_nxt    = (r_state == S_WAIT0) && (w_state_nxt == S_ZERO);
      w_level_nxt      = (w_state_nxt == S_ONE) || (w_state_nxt == S_WAIT0);
      w_press_nxt      = w_debounce_press || w_repeat_fire;
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_conditioner
//  Description : Directed self-checking bench for btn_conditioner
//                (SYNC_STAGES=2, STABLE_CYCLES=8, REPEAT_DELAY=20,
//                REPEAT_PERIOD=5, 10 ns clock).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

`ifdef BTN_AUTOREPEAT_EN
   localparam int AR = 1;
`else
   localparam int AR = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic btn_level;
   logic btn_press;
   logic btn_release;

   int n_checks = 0;
   int n_err    = 0;
   int n_press  = 0;
   int n_rel    = 0;
   int n_both   = 0;
   int p0, r0, low;

   always #5 clk = ~clk;

   btn_conditioner #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (8),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   // Strobe counters, sampled shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (btn_press === 1'b1)   n_press++;
      if (btn_release === 1'b1) n_rel++;
      if (btn_press === 1'b1 && btn_release === 1'b1) n_both++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held with the button already pressed.
      rst = 1'b0; btn_in = 1'b1;
      step(4);
      chk("rst_level",   btn_level,   0);
      chk("rst_press",   btn_press,   0);
      chk("rst_release", btn_release, 0);
      rst = 1'b1; p0 = n_press;
      step(10);
      chk("rst_press_early", btn_press, 0);
      chk("rst_level_early", btn_level, 0);
      step(1);
      chk("rst_press_edge10", btn_press, 1);
      chk("rst_level_edge10", btn_level, 1);
      step(1);
      chk("rst_press_oneshot", btn_press, 0);
      chk("rst_level_hold",    btn_level, 1);
      chk("rst_press_count",   n_press - p0, 1);
      btn_in = 1'b0; r0 = n_rel;
      step(12);
      chk("rst_back_level0",  btn_level, 0);
      chk("rst_release_count", n_rel - r0, 1);

      // Clean press held 30 cycles, then clean release.
      btn_in = 1'b1; p0 = n_press;
      step(10);
      chk("clean_press_early", btn_press, 0);
      step(1);
      chk("clean_press_edge10", btn_press, 1);
      chk("clean_level_edge10", btn_level, 1);
      step(19);
      chk("clean_press_count", n_press - p0, 1);
      btn_in = 1'b0; p0 = n_press; r0 = n_rel;
      step(10);
      chk("clean_rel_early",  btn_release, 0);
      chk("clean_level_early", btn_level,  1);
      step(1);
      chk("clean_rel_edge10",  btn_release, 1);
      chk("clean_level_low",   btn_level,   0);
      step(1);
      chk("clean_rel_oneshot", btn_release, 0);
      chk("clean_rel_count",   n_rel - r0,   1);
      chk("clean_rel_presses", n_press - p0, AR);

      // Bounce: toggle every 3 cycles for 40 cycles, then hold high.
      p0 = n_press;
      for (int i = 0; i < 40; i++) begin
         btn_in = (((i / 3) % 2) == 0);
         step(1);
      end
      chk("bounce_no_press", n_press - p0, 0);
      chk("bounce_level",    btn_level,    0);
      btn_in = 1'b1;
      step(10);
      chk("bounce_press_early", btn_press, 0);
      step(1);
      chk("bounce_press_edge10", btn_press, 1);
      chk("bounce_level_high",   btn_level, 1);

      // Release glitch of 5 cycles while settled high.
      step(5);
      r0 = n_rel; low = 0;
      btn_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (btn_level !== 1'b1) low++;
      end
      btn_in = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step(1);
         if (btn_level !== 1'b1) low++;
      end
      chk("glitch_level_drops", low, 0);
      chk("glitch_no_release",  n_rel - r0, 0);
      btn_in = 1'b0;
      step(12);
      chk("glitch_back_level0", btn_level, 0);

      // Reset asserted 4 cycles into the press qualification window.
      btn_in = 1'b1; p0 = n_press;
      step(7);
      rst = 1'b0;
      step(3);
      chk("middeb_press_in_rst", n_press - p0, 0);
      chk("middeb_level_in_rst", btn_level, 0);
      rst = 1'b1; p0 = n_press;
      step(10);
      chk("middeb_press_early", btn_press, 0);
      step(1);
      chk("middeb_press_edge10", btn_press, 1);
      chk("middeb_level_high",   btn_level, 1);
      chk("middeb_press_count",  n_press - p0, 1);

      // Long hold: auto-repeat strobes only when the feature is built.
      p0 = n_press;
      for (int i = 1; i <= 49; i++) begin
         step(1);
         if (i == 19) chk("rpt_t19", btn_press, 0);
         if (i == 20) chk("rpt_t20", btn_press, AR);
         if (i == 21) chk("rpt_t21", btn_press, 0);
         if (i == 25) chk("rpt_t25", btn_press, AR);
      end
      chk("rpt_count",  n_press - p0, AR * 6);
      chk("no_overlap", n_both, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input conditioning stage directly upstream of the 4-bit up/down counter.
- Takes one raw asynchronous board pushbutton and synchronises and debounces it.
- Emits a clean level plus single-cycle press and release strobes.
- Each strobe drives one counter control (en or load) for exactly one clk cycle per physical press.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4)
STABLE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz; minimum 2)
REPEAT_DELAY, 50000000, cycles held before the first auto-repeat press strobe (used only with the optional feature)
REPEAT_PERIOD, 10000000, cycles between later auto-repeat strobes (used only with the optional feature)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
btn_in  input  1  raw button, asynchronous to clk, may bounce
btn_level  output  1  debounced button level
btn_press  output  1  one-cycle strobe on accepted press (and on auto-repeat when enabled)
btn_release  output  1  one-cycle strobe on accepted release

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchroniser flops, timers and outputs go to 0.
  - FSM goes to S_ZERO.
  - Outputs stay 0 while rst=0; normal operation starts at the first rising edge after rst=1.
- Synchroniser: btn_in passes through SYNC_STAGES flops; the last flop output is sync_btn. The FSM uses only sync_btn.
- Debounce timer: width $clog2(STABLE_CYCLES). It is cleared on every state entry and saturates; it never wraps.
- FSM states and transitions:
  - S_ZERO: btn_level=0. If sync_btn=1, go to S_WAIT1.
  - S_WAIT1: btn_level=0. If sync_btn=0, go to S_ZERO with no strobe. Else the timer increments. When the timer equals STABLE_CYCLES-1 and sync_btn=1, go to S_ONE and assert btn_press.
  - S_ONE: btn_level=1. If sync_btn=0, go to S_WAIT0.
  - S_WAIT0: btn_level=1. If sync_btn=1, go back to S_ONE with no strobe. When the timer equals STABLE_CYCLES-1 and sync_btn=0, go to S_ZERO and assert btn_release.
- Output timing:
  - All outputs are registered.
  - btn_level and the matching strobe change on the same edge.
  - Each strobe is high for exactly one cycle.
  - btn_press and btn_release are never high together.
- Latency: count the first edge that samples btn_in=1 as edge 0. btn_press and btn_level rise after edge SYNC_STAGES+STABLE_CYCLES. Release is symmetric.
- Bounce rule: any glitch shorter than STABLE_CYCLES sync samples produces no strobe and no level change.
- Reset mid-debounce (e.g. in S_WAIT1): no strobe is emitted. After release of reset the block restarts from S_ZERO. If the button is still held, a full debounce produces a new btn_press.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN
- When defined:
  - A repeat counter of width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)) is cleared on the S_WAIT1→S_ONE transition.
  - It increments only in S_ONE and holds its value in S_WAIT0.
  - The first target is REPEAT_DELAY-1 and later targets are REPEAT_PERIOD-1.
  - On reaching the target in S_ONE, btn_press is asserted for one cycle and the counter is cleared.
- When undefined: the repeat counter is not built, and btn_press fires only on debounced press.

Decomposition:
- Package btn_pkg holds:
  - typedef enum logic[1:0] btn_state_t {S_ZERO, S_WAIT1, S_ONE, S_WAIT0}.
  - localparam defaults for STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
- Sub-module bit_sync (parameter STAGES) implements the flop chain with async active-low reset to 0. btn_conditioner instantiates it once.

Test Plan:
(All with SYNC_STAGES=2, STABLE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, 10 ns clk.)
- Reset: hold rst=0 for 4 cycles with btn_in=1 → all outputs 0. Release rst; btn_press pulses once after edge 10 and btn_level=1 from then on.
- Clean press: btn_in 0→1 held 30 cycles → exactly one btn_press, rising after edge 10. Then btn_in→0 → exactly one btn_release after edge 10 of the release, and btn_level=0.
- Bounce: toggle btn_in every 3 cycles for 40 cycles, then hold 1 → no strobe during the toggling, then a single btn_press 10 edges after the final rise.
- Release glitch: with btn_level=1, drop btn_in for 5 cycles → btn_level stays 1 and no btn_release.
- Reset mid-debounce: assert rst at 4 cycles into S_WAIT1 → no btn_press during reset. After release, one btn_press 10 edges later.
- BTN_AUTOREPEAT_EN: hold btn_in 60 cycles → btn_press at T0, T0+20, T0+25, T0+30 …. Without the macro, only the strobe at T0.
